// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: CP0 exception/interrupt controller holding SR, Cause, EPC and PrID for the M stage
module cp0_exc_ctrl #(
   parameter logic [31:0] PRID       = 32'h0000_4D50,
   parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc_M,
   input  logic        bd_M,
   input  logic [4:0]  ExcCode_M,
   input  logic [5:0]  HWInt,
   input  logic        we,
   input  logic [4:0]  rd_addr,
   input  logic [4:0]  wr_addr,
   input  logic [31:0] DIn,
   input  logic        eret_M,
   output logic [31:0] DOut,
   output logic [31:0] EPC_out,
   output logic        int_clr,
   output logic [31:0] handler_pc,
   output logic        exl
);
   logic [5:0]  im_q, im_d, ip_q, ip_d;
   logic        exl_q, exl_d, ie_q, ie_d, bd_q, bd_d;
   logic [4:0]  exc_code_q, exc_code_d;
   logic [31:0] epc_q, epc_d, pc_sel, sr, cause;
   logic        int_req, exc_req;
   assign int_req    = (|(HWInt & im_q)) & ie_q & ~exl_q;
   assign exc_req    = (ExcCode_M != 5'd0) & ~exl_q;
   assign int_clr    = ~reset & (int_req | exc_req);
   assign pc_sel     = bd_M ? pc_M - 32'd4 : pc_M;
   assign sr         = {16'b0, im_q, 8'b0, exl_q, ie_q};
   assign cause      = {bd_q, 15'b0, ip_q, 3'b0, exc_code_q, 2'b0};
   assign DOut       = rd_addr == 5'd12 ? sr :
                       rd_addr == 5'd13 ? cause :
                       rd_addr == 5'd14 ? epc_q :
                       rd_addr == 5'd15 ? PRID : 32'd0;
   assign EPC_out    = epc_q;
   assign handler_pc = HANDLER_PC;
   assign exl        = exl_q;
   // next state: exception entry beats mtc0/eret; mtc0 applies before eret clears EXL
   always_comb begin
      im_d       = im_q;
      exl_d      = exl_q;
      ie_d       = ie_q;
      bd_d       = bd_q;
      exc_code_d = exc_code_q;
      epc_d      = epc_q;
      ip_d       = HWInt;
      if (int_clr) begin
         exl_d      = 1'b1;
         exc_code_d = int_req ? 5'd0 : ExcCode_M;
         bd_d       = bd_M;
         epc_d      = pc_sel & ~32'd3;
      end else begin
         if (we && wr_addr == 5'd12) begin
            im_d  = DIn[15:10];
            exl_d = DIn[1];
            ie_d  = DIn[0];
         end
         if (we && wr_addr == 5'd14) epc_d = DIn & ~32'd3;
         if (eret_M) exl_d = 1'b0;
      end
   end
   // CP0 state registers, cleared by synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         im_q       <= '0;
         exl_q      <= 1'b0;
         ie_q       <= 1'b0;
         bd_q       <= 1'b0;
         exc_code_q <= '0;
         epc_q      <= '0;
         ip_q       <= '0;
      end else begin
         im_q       <= im_d;
         exl_q      <= exl_d;
         ie_q       <= ie_d;
         bd_q       <= bd_d;
         exc_code_q <= exc_code_d;
         epc_q      <= epc_d;
         ip_q       <= ip_d;
      end
   end
endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
Coprocessor-0 exception/interrupt controller for the 5-stage MIPS pipeline. It sits at the M stage and consumes the per-stage exception code and PC carried down the pipeline registers. It decides whether to take an exception or interrupt, and when it does, it raises int_clr to flush the pipeline registers and redirects fetch to the handler. It holds SR, Cause, EPC and PrID, serves mfc0/mtc0, and executes eret.

Parameters:
PRID, 32'h0000_4D50, read-only value returned for PrID (reg 15)
HANDLER_PC, 32'h0000_4180, exception entry address driven on handler_pc

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  synchronous, active-high
pc_M  in  32  PC of the instruction in M stage
bd_M  in  1  M-stage instruction sits in a branch delay slot
ExcCode_M  in  5  exception code carried with M-stage instr; 0 = none
HWInt  in  6  external hardware interrupt lines, level-sensitive
we  in  1  mtc0 write enable (M stage)
rd_addr  in  5  mfc0 source register number
wr_addr  in  5  mtc0 destination register number
DIn  in  32  mtc0 write data
eret_M  in  1  eret in M stage
DOut  out  32  mfc0 read data, combinational
EPC_out  out  32  current EPC, used as the eret target
int_clr  out  1  take exception/interrupt this cycle; flushes pipeline registers
handler_pc  out  32  constant HANDLER_PC
exl  out  1  SR.EXL state

Behaviour:
- Clock and reset: clk, reset are synchronous, active-high.
- Reset state: SR=0 (IM=0, EXL=0, IE=0), Cause=0, EPC=0. int_clr=0 follows from the cleared SR.
- SR layout: IM=[15:10], EXL=[1], IE=[0]. All other bits read 0.
- Cause layout: BD=[31], IP=[15:10], ExcCode=[6:2]. All other bits read 0.
- Cause is read-only to software. An mtc0 to Cause is ignored.
- PrID returns PRID. EPC bits [1:0] always read 0.
- IP register: IP <= HWInt every cycle, including the cycle an exception is taken. Not updated during reset.
- Request logic (combinational):
  - IntReq = (|(HWInt & IM)) & IE & ~EXL
  - ExcReq = (ExcCode_M != 0) & ~EXL
  - int_clr = IntReq | ExcReq
  - int_clr is asserted in the same cycle, so the pipeline registers clear on the next edge.
- Two-state mode, as seen through EXL:
  - NORMAL (EXL=0) -> EXCEPTION (EXL=1) on int_clr.
  - EXCEPTION -> NORMAL on eret_M.
  - While EXL=1 no new request is taken; nesting is disabled.
- On an edge with int_clr=1:
  - EXL <= 1.
  - ExcCode <= IntReq ? 5'd0 : ExcCode_M. Interrupt has priority over a simultaneous synchronous exception.
  - BD <= bd_M.
  - EPC <= (bd_M ? pc_M-4 : pc_M) with bits [1:0] forced to 0. 32-bit wrap on pc_M-4.
- eret_M with int_clr=0: EXL <= 0 on the edge. EPC_out presents the target.
- eret_M with int_clr=1 cannot coincide, since EXL=1 blocks requests. If forced, the int_clr update wins.
- mtc0 (we=1, int_clr=0):
  - wr_addr=12 writes SR from DIn (IM, EXL, IE bits only).
  - wr_addr=14 writes EPC = {DIn[31:2],2'b00}.
  - Other addresses are ignored.
- mtc0 with int_clr=1 is discarded; the exception update wins.
- mtc0 to SR and eret in the same cycle: the mtc0 value is written, then EXL is cleared.
- mfc0: DOut = register selected by rd_addr (12/13/14/15). Any other address returns 0.
- Read-during-write: DOut returns the old value. New values are visible the next cycle.
- Reset mid-exception: all state cleared, EXL=0, int_clr deasserts in the reset cycle.

Test Plan:
- Reset: assert reset 2 cycles -> DOut reads SR=0, Cause=0, EPC=0, PrID=32'h0000_4D50; int_clr=0.
- Interrupt: mtc0 SR=32'h0000_0401 (IM[10], IE), then HWInt=6'b000001, pc_M=32'h0000_3010, bd_M=0 -> int_clr=1 that cycle. Next cycle: EPC=32'h0000_3010, Cause=32'h0000_0400, exl=1, int_clr=0.
- Exception in delay slot: SR=0, ExcCode_M=5'd10, pc_M=32'h0000_3020, bd_M=1 -> int_clr=1. Next cycle: EPC=32'h0000_301C, Cause=32'h8000_0028.
- Priority and nesting: interrupt enabled, ExcCode_M=5'd12 and HWInt[0]=1 in the same cycle -> Cause.ExcCode=0. While exl=1, ExcCode_M=5'd4 -> int_clr stays 0.
- eret: from exl=1, pulse eret_M -> exl=0 next cycle; EPC_out unchanged. Pending masked HWInt then re-triggers int_clr the following cycle.
- mtc0 conflict: we=1, wr_addr=14, DIn=32'h1234_5677 with ExcCode_M=5'd10, pc_M=32'h0000_3040 -> EPC=32'h0000_3040. Without the exception -> EPC=32'h1234_5674.
